seg7_scan_mux: RTL

- Parametrised time-multiplexed hex driver for common-anode 7-segment displays with DIGITS digits.
- Adds to the existing 4-digit scanner:
  - a refresh prescaler;
  - per-digit decimal point and blanking;
  - tear-free frame-synchronous data loading;
  - an anti-ghosting guard cycle.
- Sits between the CPU bus/LED register and the board AN/segment pins.

---
 rtl/seg7_scan_mux.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-anode hex driver: prescaled digit scan, guard cycle, frame-synchronous loading.
// Optional build macro SEG7_LZ_BLANK_EN enables leading-zero suppression on the display register.

module seg7_digit (
  input  logic [3:0] nib,
  input  logic       dp,
  input  logic       dark,
  output logic [7:0] seg
);
  logic [6:0] pat;

  // Active-low segments g..a.
  always_comb begin
    pat = 7'h7F;
    case (nib)
      4'h0: pat = 7'h40;
      4'h1: pat = 7'h79;
      4'h2: pat = 7'h24;
      4'h3: pat = 7'h30;
      4'h4: pat = 7'h19;
      4'h5: pat = 7'h12;
      4'h6: pat = 7'h02;
      4'h7: pat = 7'h78;
      4'h8: pat = 7'h00;
      4'h9: pat = 7'h10;
      4'hA: pat = 7'h08;
      4'hB: pat = 7'h03;
      4'hC: pat = 7'h46;
      4'hD: pat = 7'h21;
      4'hE: pat = 7'h06;
      4'hF: pat = 7'h0E;
    endcase
  end

  assign seg = dark ? 8'hFF : {~dp, pat};
endmodule

module seg7_scan_mux #(
  parameter int DIGITS  = 4,
  parameter int CLK_DIV = 16,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  load,
  output logic [DIGITS-1:0]     AN,
  output logic [7:0]            data_out,
  output logic                  frame_tick
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  typedef struct packed {
    logic [DIGITS-1:0][3:0] nib;
    logic [DIGITS-1:0]      dp;
    logic [DIGITS-1:0]      blank;
  } frame_t;

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  frame_t                  disp, pend, in_frm;
  logic                    pend_vld;
  logic                    cnt_last, fe;
  logic [DIGITS-1:0]       lz, dark;
  logic [DIGITS-1:0][7:0]  dig_seg;
  logic [DIGITS-1:0]       an_nxt;
  logic [7:0]              seg_nxt;

  assign in_frm   = {data_in, dp_in, blank_in};
  assign cnt_last = (cnt == CNT_LAST);
  assign fe       = cnt_last && (idx == IDX_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt_last) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Display only changes at frame end so a frame is never torn; a load landing
  // on the frame-end cycle itself wins over whatever is pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp       <= '0;
      pend       <= '0;
      pend_vld   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (fe) begin
        if (load)          disp <= in_frm;
        else if (pend_vld) disp <= pend;
        frame_tick <= load | pend_vld;
        pend_vld   <= 1'b0;
      end else if (load) begin
        pend     <= in_frm;
        pend_vld <= 1'b1;
      end
    end
  end

`ifdef SEG7_LZ_BLANK_EN
  logic lead;
  // Walk down from the top digit; a lit dp or a nonzero digit ends the run.
  always_comb begin
    lz   = '0;
    lead = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      lz[k] = lead && (disp.nib[k] == 4'h0) && !disp.dp[k];
      lead  = lead && (lz[k] || disp.blank[k]);
    end
  end
`else
  assign lz = '0;
`endif

  assign dark = disp.blank | lz;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    seg7_digit u_dig (
      .nib  (disp.nib[g]),
      .dp   (disp.dp[g]),
      .dark (dark[g]),
      .seg  (dig_seg[g])
    );
  end

  // cnt == 0 is the dark guard slot that hides anode switching ghosts.
  always_comb begin
    an_nxt  = '1;
    seg_nxt = 8'hFF;
    if (cnt != '0) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (idx == IDX_W'(k)) begin
          an_nxt[k] = 1'b0;
          seg_nxt   = dig_seg[k];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      AN       <= '1;
      data_out <= 8'hFF;
    end else begin
      AN       <= an_nxt;
      data_out <= seg_nxt;
    end
  end
endmodule
